effect_program_encoder: RTL and testbench

- Writer side of the 4-slot opcode program consumed by the decoration sequencer.
- Accepts one-hot effect requests and priority-encodes each into a 4-bit opcode: ON=0000, RESET=0001, GREEN=0100, PURPLE=0101, ORANGE=0110, SCREAMING=1000, CACKLING=1001, BOO=1010, WAVEHANDS=1100, MOVEJAW=1101, FOG=1110.
- Packs opcodes into a 16-bit program and hands it off with a valid/ready handshake.
- Guarantees slot 0 of every emitted program is non-zero, so the sequencer never sees a spurious all-zero first channel.

---
 rtl/effect_program_encoder.sv | 160 ++++++++++++++++
 tb/tb_effect_program_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/effect_program_encoder.sv
// rtl/effect_program_encoder.sv - priority-encodes effect requests into a 4-slot opcode program
module effect_program_encoder #(
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_onehot,
  output logic        req_ready,
  output logic        prog_valid,
  output logic [15:0] prog_data,
  input  logic        prog_ready,
  output logic [2:0]  count,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [3:0][3:0]    slots_q, slots_d;
  logic [2:0]         count_q, count_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [15:0]        prog_data_q, prog_data_d;
  logic               prog_valid_q, prog_valid_d;
  logic               err_q, err_d;

  logic [3:0]         enc_idx;
  logic               enc_none;
  logic               accept;
  logic               is_reject;
  logic               is_reset;
  logic               is_store;
  logic               full;
  logic               timeout;
  logic               handshake;

  // Lowest set bit wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    enc_idx  = 4'd0;
    enc_none = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      if (req_onehot[i]) begin
        enc_idx  = 4'(i);
        enc_none = 1'b0;
      end
    end
  end

  // Request classification. ON with an empty buffer is neither stored nor an
  // error, which keeps slot 0 of every program non-zero.
  assign accept    = req_valid & req_ready;
  assign is_reject = enc_none | (enc_idx[1:0] == 2'b11);
  assign is_reset  = accept & ~is_reject & (enc_idx == 4'd1);
  assign is_store  = accept & ~is_reject & (enc_idx != 4'd1) &
                     ~((enc_idx == 4'd0) & (count_q == 3'd0));
  assign full      = is_store & (count_q == 3'd3);
  assign timeout   = (state_q == FILL) & ~accept & (timer_q == TIMER_LAST);
  assign handshake = (state_q == SEND) & prog_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a full store beats a simultaneous timeout since a store
  // counts as activity.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (is_store) state_d = FILL;
      end
      FILL: begin
        if (is_reset)              state_d = IDLE;
        else if (full || timeout)  state_d = SEND;
      end
      SEND: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: requests are only taken while no program is pending.
  always_comb begin
    req_ready = (state_q != SEND);
  end

  // Datapath next values: slots, fill count, idle timer and the program register.
  always_comb begin
    slots_d      = slots_q;
    count_d      = count_q;
    timer_d      = timer_q;
    prog_data_d  = prog_data_q;
    prog_valid_d = prog_valid_q;
    err_d        = accept & is_reject;
    if (is_reset) begin
      slots_d = '0;
      count_d = 3'd0;
      timer_d = '0;
    end else if (is_store) begin
      slots_d[count_q[1:0]] = enc_idx;
      count_d               = count_q + 3'd1;
      timer_d               = '0;
      if (full) begin
        prog_valid_d = 1'b1;
        prog_data_d  = slots_d;
      end
    end else if (timeout) begin
      // Unfilled slots are already zero, so the padding comes for free.
      prog_valid_d = 1'b1;
      prog_data_d  = slots_q;
    end else if ((state_q == FILL) && !accept) begin
      timer_d = timer_q + TO_W'(1);
    end
    if (handshake) begin
      slots_d      = '0;
      count_d      = 3'd0;
      timer_d      = '0;
      prog_valid_d = 1'b0;
      prog_data_d  = '0;
    end
  end

  // Datapath registers, cleared asynchronously so a pending program is dropped at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_q      <= '0;
      count_q      <= 3'd0;
      timer_q      <= '0;
      prog_data_q  <= '0;
      prog_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      slots_q      <= slots_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      prog_data_q  <= prog_data_d;
      prog_valid_q <= prog_valid_d;
      err_q        <= err_d;
    end
  end

  assign prog_valid = prog_valid_q;
  assign prog_data  = prog_data_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_effect_program_encoder.sv
// tb/tb_effect_program_encoder.sv - scoreboard bench for effect_program_encoder
module tb_effect_program_encoder;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_onehot = 16'h0;
  logic        prog_ready = 1'b0;
  logic        req_ready;
  logic        prog_valid;
  logic [15:0] prog_data;
  logic [2:0]  count;
  logic        err;

  effect_program_encoder #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_onehot (req_onehot),
    .req_ready  (req_ready),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered opcodes, idle-cycle count, pending-program flag.
  int          mbuf[$];
  bit          msend = 1'b0;
  int          midle = 0;
  logic [15:0] exp_data[$];
  int          exp_cnt[$];
  int          err_tok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] pack_buf();
    logic [15:0] d = 16'h0;
    for (int i = 0; i < mbuf.size(); i++) d = d | (16'(mbuf[i]) << (4 * i));
    return d;
  endfunction

  task automatic model_reset();
    mbuf.delete();
    msend = 1'b0;
    midle = 0;
  endtask

  // Advance the model across one clock edge given the inputs presented for it.
  task automatic model_step(input bit v, input logic [15:0] oh, input bit pr);
    int idx;
    bit acc;
    acc = v && !msend;
    idx = lowest(oh);
    if (msend) begin
      if (pr) model_reset();
    end else if (acc) begin
      if (idx < 0 || (idx % 4) == 3) begin
        err_tok++;
      end else if (idx == 1) begin
        mbuf.delete();
        midle = 0;
      end else if (idx == 0 && mbuf.size() == 0) begin
        midle = 0;
      end else begin
        mbuf.push_back(idx);
        midle = 0;
        if (mbuf.size() == 4) begin
          exp_data.push_back(pack_buf());
          exp_cnt.push_back(4);
          msend = 1'b1;
        end
      end
    end else if (mbuf.size() > 0) begin
      midle++;
      if (midle >= TIMEOUT) begin
        exp_data.push_back(pack_buf());
        exp_cnt.push_back(mbuf.size());
        msend = 1'b1;
      end
    end
  endtask

  // One clock: check state after the edge, then present inputs for the next edge.
  task automatic cycle(input bit v, input logic [15:0] oh, input bit pr);
    @(posedge clk);
    #1;
    chk("req_ready", req_ready, !msend);
    chk("prog_valid", prog_valid, msend);
    chk("count", count, mbuf.size());
    req_valid  = v;
    req_onehot = oh;
    prog_ready = pr;
    model_step(v, oh, pr);
  endtask

  task automatic wait_prog(input string name, input logic [15:0] exp);
    for (int i = 0; i < 12; i++) begin
      if (prog_valid) break;
      cycle(1'b0, 16'h0, 1'b0);
    end
    chk(name, prog_data, exp);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every program handshake and every err pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (prog_valid && prog_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_prog: got %0h expected none", prog_data);
        end else begin
          chk("prog_data", prog_data, exp_data.pop_front());
          chk("prog_count", count, exp_cnt.pop_front());
        end
      end
      if (err) begin
        checks++;
        if (err_tok == 0) begin
          errors++;
          $display("FAIL unexpected_err: got 1 expected 0 at %0t", $time);
        end else begin
          err_tok--;
        end
      end
    end
  end

  initial begin
    logic [15:0] oh;
    int          idx;
    #2 rst = 1'b0;
    #8;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_prog_valid", prog_valid, 0);
    chk("rst_prog_data", prog_data, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    #2 rst = 1'b1;

    // Full program, consumer ready.
    cycle(1'b1, 16'h0010, 1'b1);
    cycle(1'b1, 16'h0020, 1'b1);
    cycle(1'b1, 16'h2000, 1'b1);
    cycle(1'b1, 16'h1000, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    chk("full_data", prog_data, 16'hCD54);
    cycle(1'b0, 16'h0, 1'b1);

    // Priority and rejects.
    cycle(1'b1, 16'h0120, 1'b1);
    cycle(1'b1, 16'h0008, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1);
    cycle(1'b1, 16'h8000, 1'b1);
    wait_prog("priority_data", 16'h0005);

    // Timeout after exactly TIMEOUT idle cycles.
    cycle(1'b1, 16'h0040, 1'b1);
    cycle(1'b1, 16'h0100, 1'b0);
    repeat (TIMEOUT) cycle(1'b0, 16'h0, 1'b0);
    chk("to_early", prog_valid, 0);
    cycle(1'b0, 16'h0, 1'b0);
    chk("to_valid", prog_valid, 1);
    chk("to_data", prog_data, 16'h0086);
    chk("to_count", count, 2);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);

    // Asynchronous reset mid-fill.
    cycle(1'b1, 16'h0010, 1'b1);
    cycle(1'b1, 16'h0020, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    chk("pre_rst_count", count, 2);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_prog_valid", prog_valid, 0);
    chk("mid_rst_prog_data", prog_data, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    model_reset();
    #1 rst = 1'b1;
    cycle(1'b1, 16'h0200, 1'b1);
    wait_prog("slot0_after_reset", 16'h0009);

    // Control opcodes.
    cycle(1'b1, 16'h0001, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    chk("on_dropped_count", count, 0);
    cycle(1'b1, 16'h0010, 1'b1);
    cycle(1'b1, 16'h0040, 1'b1);
    cycle(1'b1, 16'h0200, 1'b1);
    cycle(1'b1, 16'h0002, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    chk("reset_op_count", count, 0);
    repeat (TIMEOUT + 2) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'h4000, 1'b1);
    cycle(1'b1, 16'h0001, 1'b1);
    wait_prog("on_filler", 16'h000E);

    // Backpressure with a request held during SEND.
    cycle(1'b1, 16'h0010, 1'b0);
    cycle(1'b1, 16'h0020, 1'b0);
    cycle(1'b1, 16'h2000, 1'b0);
    cycle(1'b1, 16'h1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'h0400, 1'b0);
      chk("bp_data", prog_data, 16'hCD54);
      chk("bp_req_ready", req_ready, 0);
    end
    cycle(1'b1, 16'h0400, 1'b1);
    cycle(1'b1, 16'h0400, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    chk("bp_held_accepted", count, 1);
    wait_prog("bp_held_data", 16'h000A);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        oh = 16'h0;
      end else begin
        idx = $urandom_range(0, 15);
        if (idx == 1 && $urandom_range(0, 1) == 0) idx = $urandom_range(4, 15);
        oh = 16'(32'd1 << idx) | (16'($urandom) & 16'(~((32'd2 << idx) - 32'd1)));
      end
      cycle(1'($urandom_range(0, 1)), oh, ($urandom_range(0, 3) != 0));
    end

    repeat (2 * TIMEOUT + 6) cycle(1'b0, 16'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("exp_queue_empty", exp_data.size(), 0);
    chk("err_tokens_left", err_tok, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
